mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/soc_6502_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_6502_pkg.sv
// Shared types and constants for the 6502 SoC: memory owner encoding and read tags.
package soc_6502_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int STARVE_LIMIT_DEFAULT = 7;
  localparam int MAX_BURST_DEFAULT    = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the 6502 core and a DMA/loader master.
// CPU has priority; DMA is forced in after STARVE_LIMIT CPU wins and may burst up to MAX_BURST.
module mem_arbiter
  import soc_6502_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int MAX_BURST    = MAX_BURST_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_rdy,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  owner_e        r_state;
  owner_e        w_state_next;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_next;
  logic [BW-1:0] r_burst_cnt;
  logic [BW-1:0] w_burst_next;
  rd_tag_t       r_tag;
  logic [DW-1:0] r_cpu_rdata;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;
  logic          w_starved;
  logic          w_burst_done;
  logic          w_cpu_ret;

  assign w_starved    = dma_req && (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_burst_done = (r_burst_cnt >= BW'(MAX_BURST));

  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_dma_gnt    = 1'b0;
    w_state_next = r_state;
    w_burst_next = r_burst_cnt;
    if (!reset) begin
      case (r_state)
        OWN_CPU: begin
          if (cpu_req && !w_starved) begin
            w_cpu_gnt = 1'b1;
          end else if (dma_req) begin
            w_dma_gnt    = 1'b1;
            w_state_next = OWN_DMA;
            w_burst_next = BW'(1);
          end
        end
        OWN_DMA: begin
          if (dma_req && !w_burst_done) begin
            w_dma_gnt    = 1'b1;
            w_burst_next = r_burst_cnt + BW'(1);
          end else if (cpu_req) begin
            w_cpu_gnt    = 1'b1;
            w_state_next = OWN_CPU;
            w_burst_next = '0;
          end else if (dma_req) begin
            // Burst exhausted but the CPU is idle: hand ownership straight back as a fresh burst.
            w_dma_gnt    = 1'b1;
            w_burst_next = BW'(1);
          end else begin
            w_state_next = OWN_CPU;
            w_burst_next = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_dma_gnt || !dma_req) begin
      w_starve_next = '0;
    end else if (w_cpu_gnt && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      w_starve_next = r_starve_cnt + SW'(1);
    end
  end

  assign cpu_rdy   = w_cpu_gnt;
  assign dma_gnt   = w_dma_gnt;
  assign mem_en    = w_cpu_gnt | w_dma_gnt;
  assign mem_we    = (w_cpu_gnt & cpu_we) | (w_dma_gnt & dma_we);
  assign mem_addr  = w_dma_gnt ? dma_addr : cpu_addr;
  assign mem_wdata = w_dma_gnt ? dma_wdata : cpu_wdata;

  // Read data is steered by the tag registered when the read was issued.
  assign w_cpu_ret  = r_tag.valid && (r_tag.owner == OWN_CPU) && !reset;
  assign dma_rvalid = r_tag.valid && (r_tag.owner == OWN_DMA) && !reset;
  assign dma_rdata  = mem_rdata;
  assign cpu_rdata  = w_cpu_ret ? mem_rdata : r_cpu_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= OWN_CPU;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
      r_tag        <= '{valid: 1'b0, owner: OWN_CPU};
      r_cpu_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      r_burst_cnt  <= w_burst_next;
      r_tag.valid  <= mem_en && !mem_we;
      r_tag.owner  <= w_dma_gnt ? OWN_DMA : OWN_CPU;
      if (w_cpu_ret) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle-latency RAM model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_rdy;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(7), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end else if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
    #1;
    n_total++;
    if ({cpu_rdy, dma_gnt, mem_en, mem_we} !== 4'b0000)
      $display("FAIL reset_outputs: got rdy/gnt/en/we=%b expected 0000", {cpu_rdy, dma_gnt, mem_en, mem_we});
    else n_pass++;
    n_total++;
    if (dma_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", dma_rvalid);
    else n_pass++;
    n_total++;
    if (cpu_rdata !== 8'h00) $display("FAIL reset_cpu_rdata: got %h expected 00", cpu_rdata);
    else n_pass++;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
      #1;
      n_total++;
      if ({cpu_rdy, dma_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 16'h0200)
        $display("FAIL cpu_read_grant[%0d]: got rdy/gnt/en/we=%b addr=%h expected 1010 addr=0200",
                 i, {cpu_rdy, dma_gnt, mem_en, mem_we}, mem_addr);
      else n_pass++;
      n_total++;
      if (cpu_rdata !== ((i == 0) ? 8'h00 : 8'hA5))
        $display("FAIL cpu_read_data[%0d]: got %h expected %h", i, cpu_rdata, (i == 0) ? 8'h00 : 8'hA5);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      #1;
      n_total++;
      if (cpu_rdata !== 8'hA5 || mem_en !== 1'b0 || dma_rvalid !== 1'b0)
        $display("FAIL cpu_read_hold[%0d]: got rdata=%h en=%b rvalid=%b expected A5 0 0",
                 i, cpu_rdata, mem_en, dma_rvalid);
      else n_pass++;
    end
    $display("test_cpu_read done");
  endtask

  task automatic test_dma_write();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b1;
      dma_addr = 16'h0300 + 16'(i); dma_wdata = 8'h60 + 8'(i);
      #1;
      n_total++;
      if ({dma_gnt, cpu_rdy, mem_we, dma_rvalid} !== 4'b1010 ||
          mem_addr !== 16'h0300 + 16'(i) || mem_wdata !== 8'h60 + 8'(i))
        $display("FAIL dma_write[%0d]: got gnt/rdy/we/rv=%b addr=%h wdata=%h expected 1010 %h %h",
                 i, {dma_gnt, cpu_rdy, mem_we, dma_rvalid}, mem_addr, mem_wdata,
                 16'h0300 + 16'(i), 8'h60 + 8'(i));
      else n_pass++;
    end
    idle_cycle();
    #1;
    n_total++;
    if (dma_rvalid !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL dma_write_tail: got rvalid=%b en=%b expected 0 0", dma_rvalid, mem_en);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (ram[16'h0300 + 16'(i)] !== 8'h60 + 8'(i))
        $display("FAIL dma_write_ram[%0d]: got %h expected %h", i, ram[16'h0300 + 16'(i)], 8'h60 + 8'(i));
      else n_pass++;
    end
    dma_we = 1'b0;
    $display("test_dma_write done");
  endtask

  // Both requesters rise together: CPU wins 7 cycles, DMA enters on the 8th.
  task automatic test_simultaneous();
    idle_cycle();
    idle_cycle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
      #1;
      n_total++;
      if ({cpu_rdy, dma_gnt} !== ((k < 7) ? 2'b10 : 2'b01))
        $display("FAIL simultaneous[%0d]: got rdy/gnt=%b expected %b", k, {cpu_rdy, dma_gnt},
                 (k < 7) ? 2'b10 : 2'b01);
      else n_pass++;
    end
    idle_cycle();
    idle_cycle();
    $display("test_simultaneous done");
  endtask

  task automatic test_starvation();
    int stall = 0;
    int max_stall = 0;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
      #1;
      n_total++;
      if ({cpu_rdy, dma_gnt} !== (((k % 11) < 7) ? 2'b10 : 2'b01))
        $display("FAIL starvation[%0d]: got rdy/gnt=%b expected %b", k, {cpu_rdy, dma_gnt},
                 ((k % 11) < 7) ? 2'b10 : 2'b01);
      else n_pass++;
      stall = cpu_rdy ? 0 : stall + 1;
      if (stall > max_stall) max_stall = stall;
    end
    n_total++;
    if (max_stall > 4) $display("FAIL starvation_max_stall: got %0d expected <=4", max_stall);
    else n_pass++;
    idle_cycle();
    #1;
    n_total++;
    if (mem_en !== 1'b0) $display("FAIL starvation_idle: got en=%b expected 0", mem_en);
    else n_pass++;
    $display("test_starvation done");
  endtask

  task automatic test_dma_read();
    idle_cycle();
    #1;
    n_total++;
    if (cpu_rdata !== 8'h77) $display("FAIL dma_read_pre_cpu_rdata: got %h expected 77", cpu_rdata);
    else n_pass++;
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0400;
    #1;
    n_total++;
    if ({dma_gnt, cpu_rdy, mem_we} !== 3'b100 || mem_addr !== 16'h0400)
      $display("FAIL dma_read_grant: got gnt/rdy/we=%b addr=%h expected 100 0400",
               {dma_gnt, cpu_rdy, mem_we}, mem_addr);
    else n_pass++;
    idle_cycle();
    #1;
    n_total++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3C)
      $display("FAIL dma_read_return: got rvalid=%b rdata=%h expected 1 3C", dma_rvalid, dma_rdata);
    else n_pass++;
    n_total++;
    if (cpu_rdata !== 8'h77) $display("FAIL dma_read_cpu_rdata: got %h expected 77", cpu_rdata);
    else n_pass++;
    idle_cycle();
    #1;
    n_total++;
    if (dma_rvalid !== 1'b0) $display("FAIL dma_read_single: got rvalid=%b expected 0", dma_rvalid);
    else n_pass++;
    $display("test_dma_read done");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0500;
    #1;
    n_total++;
    if (dma_gnt !== 1'b1) $display("FAIL midburst_first_gnt: got %b expected 1", dma_gnt);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1; dma_addr = 16'h0501;
    #1;
    n_total++;
    if ({dma_gnt, cpu_rdy, mem_en} !== 3'b000)
      $display("FAIL midburst_reset_held: got gnt/rdy/en=%b expected 000", {dma_gnt, cpu_rdy, mem_en});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; dma_req = 1'b0;
    #1;
    n_total++;
    if (dma_rvalid !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL midburst_dropped: got rvalid=%b en=%b expected 0 0", dma_rvalid, mem_en);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_addr = 16'h0020;
      #1;
      n_total++;
      if ({cpu_rdy, dma_gnt} !== ((k < 7) ? 2'b10 : 2'b01))
        $display("FAIL midburst_restart[%0d]: got rdy/gnt=%b expected %b", k, {cpu_rdy, dma_gnt},
                 (k < 7) ? 2'b10 : 2'b01);
      else n_pass++;
    end
    idle_cycle();
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    load(16'h0200, 8'hA5);
    load(16'h0010, 8'h77);
    load(16'h0020, 8'hD2);
    load(16'h0400, 8'h3C);
    load(16'h0500, 8'h11);
    load(16'h0501, 8'h22);
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_starvation();
    test_dma_read();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
